thread_registers: RTL and testbench

//  Per-thread register file: 16 x 8-bit registers for one thread of one core.

---
 rtl/gpu_pkg.sv | 26 ++
 rtl/thread_registers.sv | 112 +++++++++++
 tb/tb_thread_registers.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: core FSM state encodings, writeback source select codes and
// the fixed indices of the read-only special registers.
package gpu_pkg;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  localparam logic [1:0] REG_SRC_ALU  = 2'b00;
  localparam logic [1:0] REG_SRC_LSU  = 2'b01;
  localparam logic [1:0] REG_SRC_IMM  = 2'b10;
  localparam logic [1:0] REG_SRC_RSVD = 2'b11;

  localparam int unsigned NUM_REGS = 16;

  localparam logic [3:0] REG_LAST_GP    = 4'd12;
  localparam logic [3:0] REG_BLOCK_IDX  = 4'd13;
  localparam logic [3:0] REG_BLOCK_DIM  = 4'd14;
  localparam logic [3:0] REG_THREAD_IDX = 4'd15;

endpackage

// File: rtl/thread_registers.sv
// Per-thread 16-entry register file; R13..R15 hold %blockIdx, %blockDim, %threadIdx.
// Define REGFILE_PARITY_EN to store an even-parity bit per register with a sticky error flag.
module thread_registers
  import gpu_pkg::*;
#(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned THREAD_ID         = 0,
  parameter int unsigned DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic [3:0]           decoded_rd_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt,
  output logic                 parity_error
);

  localparam logic [DATA_BITS-1:0] BlockDimVal = DATA_BITS'(THREADS_PER_BLOCK);
  localparam logic [DATA_BITS-1:0] ThreadIdVal = DATA_BITS'(THREAD_ID);

  logic [DATA_BITS-1:0] reg_q [NUM_REGS];
  logic [DATA_BITS-1:0] rs_q, rt_q;
  logic [DATA_BITS-1:0] block_idx_d;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_src_ok;
  logic                 wr_en;
  logic                 rd_en;

  assign block_idx_d = DATA_BITS'(block_id);
  assign rd_en       = (core_state == CORE_REQUEST);

  always_comb begin
    wr_data   = alu_out;
    wr_src_ok = 1'b1;
    case (decoded_reg_input_mux)
      REG_SRC_ALU: wr_data = alu_out;
      REG_SRC_LSU: wr_data = lsu_out;
      REG_SRC_IMM: wr_data = decoded_immediate;
      default:     wr_src_ok = 1'b0;
    endcase
    // Writes to the special registers are dropped silently
    wr_en = (core_state == CORE_UPDATE) && decoded_reg_write_enable && wr_src_ok &&
            (decoded_rd_address <= REG_LAST_GP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= '0;
      end
      reg_q[REG_BLOCK_DIM]  <= BlockDimVal;
      reg_q[REG_THREAD_IDX] <= ThreadIdVal;
      rs_q                  <= '0;
      rt_q                  <= '0;
    end else if (enable) begin
      reg_q[REG_BLOCK_IDX] <= block_idx_d;
      if (rd_en) begin
        rs_q <= reg_q[decoded_rs_address];
        rt_q <= reg_q[decoded_rt_address];
      end
      if (wr_en) begin
        reg_q[decoded_rd_address] <= wr_data;
      end
    end
  end

  assign rs = rs_q;
  assign rt = rt_q;

`ifdef REGFILE_PARITY_EN
  logic par_q [NUM_REGS];
  logic par_err_q;
  logic rs_bad, rt_bad;

  assign rs_bad = (^reg_q[decoded_rs_address]) != par_q[decoded_rs_address];
  assign rt_bad = (^reg_q[decoded_rt_address]) != par_q[decoded_rt_address];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        par_q[i] <= 1'b0;
      end
      par_q[REG_BLOCK_DIM]  <= ^BlockDimVal;
      par_q[REG_THREAD_IDX] <= ^ThreadIdVal;
      par_err_q             <= 1'b0;
    end else if (enable) begin
      par_q[REG_BLOCK_IDX] <= ^block_idx_d;
      if (wr_en) begin
        par_q[decoded_rd_address] <= ^wr_data;
      end
      if (rd_en && (rs_bad || rt_bad)) begin
        par_err_q <= 1'b1;
      end
    end
  end

  assign parity_error = par_err_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_thread_registers.sv
// Scoreboard bench for thread_registers: REQUEST expectations queued at drive time,
// popped and compared one cycle later when rs/rt update.
module tb_thread_registers;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_REQ  = 3'b011;
  localparam logic [2:0] ST_UPD  = 3'b110;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] block_id;
  logic [2:0] core_state;
  logic [3:0] rs_addr, rt_addr, rd_addr;
  logic       we;
  logic [1:0] mux;
  logic [7:0] imm, alu_out, lsu_out;
  logic [7:0] rs, rt;
  logic       parity_error;

  always #5 clk = ~clk;

  thread_registers #(
    .THREADS_PER_BLOCK(4),
    .THREAD_ID        (2),
    .DATA_BITS        (8)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .block_id                (block_id),
    .core_state              (core_state),
    .decoded_rs_address      (rs_addr),
    .decoded_rt_address      (rt_addr),
    .decoded_rd_address      (rd_addr),
    .decoded_reg_write_enable(we),
    .decoded_reg_input_mux   (mux),
    .decoded_immediate       (imm),
    .alu_out                 (alu_out),
    .lsu_out                 (lsu_out),
    .rs                      (rs),
    .rt                      (rt),
    .parity_error            (parity_error)
  );

  typedef struct {
    string      tag;
    logic [7:0] rs;
    logic [7:0] rt;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mdl [16];
  logic       nxt_en;
  logic [7:0] nxt_bid;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    mdl[14] = 8'd4;
    mdl[15] = 8'd2;
  endtask

  // One clock of stimulus; the model tracks what the register file should hold afterwards
  task automatic step(input string tag, input logic [2:0] st, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] d, input logic w,
                      input logic [1:0] m, input logic [7:0] alu, input logic [7:0] lsu,
                      input logic [7:0] im);
    exp_t e;
    @(negedge clk);
    enable = nxt_en; block_id = nxt_bid;
    core_state = st; rs_addr = a; rt_addr = b; rd_addr = d;
    we = w; mux = m; alu_out = alu; lsu_out = lsu; imm = im;
    if (enable) begin
      if (st == ST_REQ) begin
        e.tag = tag; e.rs = mdl[a]; e.rt = mdl[b];
        sb_q.push_back(e);
      end
      if (st == ST_UPD && w && d <= 4'd12 && m != 2'b11)
        mdl[d] = (m == 2'b00) ? alu : (m == 2'b01) ? lsu : im;
      mdl[13] = block_id;
    end
  endtask

  task automatic idle();
    step("idle", ST_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic req(input string tag, input logic [3:0] a, input logic [3:0] b);
    step(tag, ST_REQ, a, b, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    idle();
  endtask

  task automatic upd(input logic [3:0] d, input logic [1:0] m, input logic [7:0] alu,
                     input logic [7:0] lsu, input logic [7:0] im);
    step("upd", ST_UPD, 4'd0, 4'd0, d, 1'b1, m, alu, lsu, im);
    idle();
  endtask

  // Output monitor: a REQUEST accepted at this edge shows on rs/rt just after it
  always @(posedge clk) begin
    logic fire;
    exp_t e;
    fire = reset && enable && (core_state == ST_REQ);
    #1;
    if (fire) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_rs"}, rs, e.rs);
        check({e.tag, "_rt"}, rt, e.rt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; enable = 1'b1; block_id = 8'h00; core_state = ST_IDLE;
    rs_addr = 4'd0; rt_addr = 4'd0; rd_addr = 4'd0; we = 1'b0; mux = 2'b00;
    imm = 8'h00; alu_out = 8'h00; lsu_out = 8'h00;
    nxt_en = 1'b1; nxt_bid = 8'h00;
    mdl_reset();

    repeat (2) @(negedge clk);
    #1;
    check("rst_rs", rs, 8'h00);
    check("rst_rt", rt, 8'h00);
    check("rst_parity", parity_error, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Special registers after reset
    req("t1_dim_tid", 4'd14, 4'd15);
    req("t1_r13_r0", 4'd13, 4'd0);

    // ALU and LSU writeback, then rs==rt==rd
    upd(4'd3, 2'b00, 8'h5A, 8'h00, 8'h00);
    upd(4'd7, 2'b01, 8'h00, 8'hC3, 8'h00);
    req("t2_alu_lsu", 4'd3, 4'd7);
    upd(4'd3, 2'b10, 8'h00, 8'h00, 8'h96);
    req("t2_same", 4'd3, 4'd3);

    // Read-only targets, reserved mux, write enable low
    upd(4'd15, 2'b10, 8'h00, 8'h00, 8'hFF);
    upd(4'd13, 2'b00, 8'hEE, 8'h00, 8'h00);
    req("t3_ro", 4'd15, 4'd14);
    upd(4'd4, 2'b10, 8'h00, 8'h00, 8'h33);
    upd(4'd4, 2'b11, 8'h44, 8'h55, 8'h66);
    step("nowe", ST_UPD, 4'd0, 4'd0, 4'd8, 1'b0, 2'b00, 8'h77, 8'h77, 8'h77);
    idle();
    req("t3_rsvd_nowe", 4'd4, 4'd8);
    upd(4'd12, 2'b00, 8'hA5, 8'h00, 8'h00);
    req("t3_r12_r0", 4'd12, 4'd0);

    // %blockIdx refresh and enable freeze
    nxt_bid = 8'd9;
    idle();
    req("t4_bid", 4'd13, 4'd3);
    nxt_en = 1'b0; nxt_bid = 8'd5;
    req("t4_off", 4'd14, 4'd15);
    #1;
    check("t4_frozen_rs", rs, 8'h09);
    check("t4_frozen_rt", rt, 8'h96);
    upd(4'd9, 2'b00, 8'hAA, 8'h00, 8'h00);
    nxt_en = 1'b1;
    req("t4_r13_held", 4'd13, 4'd9);
    req("t4_r13_new", 4'd13, 4'd13);

    // Asynchronous reset in the middle of an UPDATE
    upd(4'd5, 2'b00, 8'h11, 8'h00, 8'h00);
    req("t5_pre", 4'd5, 4'd5);
    @(negedge clk);
    core_state = ST_UPD; rd_addr = 4'd5; we = 1'b1; mux = 2'b00; alu_out = 8'h22;
    #2 reset = 1'b0;
    #1;
    check("t5_async_rs", rs, 8'h00);
    check("t5_async_rt", rt, 8'h00);
    #3 core_state = ST_IDLE; we = 1'b0;
    #1 reset = 1'b1;
    mdl_reset();
    req("t5_r5_dim", 4'd5, 4'd14);
    req("t5_tid_r13", 4'd15, 4'd13);
    req("t5_r3_r13", 4'd3, 4'd13);

`ifdef REGFILE_PARITY_EN
    upd(4'd6, 2'b00, 8'h3C, 8'h00, 8'h00);
    req("t6_clean", 4'd6, 4'd6);
    #1;
    check("t6_no_err", parity_error, 1'b0);
    dut.reg_q[6] = dut.reg_q[6] ^ 8'h01;
    mdl[6] = mdl[6] ^ 8'h01;
    req("t6_flip", 4'd6, 4'd0);
    #1;
    check("t6_err_set", parity_error, 1'b1);
    upd(4'd6, 2'b00, 8'h00, 8'h00, 8'h00);
    req("t6_after", 4'd6, 4'd1);
    #1;
    check("t6_err_sticky", parity_error, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_err_cleared", parity_error, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    mdl_reset();
`else
    check("parity_tied", parity_error, 1'b0);
`endif

    idle();
    idle();
    check("sb_drain", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
